// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the packed control bundle and the RUN-state decision helper.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_WAIT  = 2'd1,
        HZ_ERROR = 2'd2
    } hz_state_t;

    localparam int MEM_TIMEOUT_DEF = 64;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN = 7'b1111_000;
    localparam hz_ctrl_t CTRL_BR  = 7'b1111_110;
    localparam hz_ctrl_t CTRL_LU  = 7'b0011_010;
    localparam hz_ctrl_t CTRL_MS  = 7'b0000_001;

    // Taken branch squashes the consumer, so it outranks load-use.
    function automatic hz_ctrl_t hz_decide(input logic br,
                                           input logic lu);
        hz_ctrl_t c;
        c = CTRL_RUN;
        priority case (1'b1)
            br:      c = CTRL_BR;
            lu:      c = CTRL_LU;
            default: c = CTRL_RUN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM observations in, pipeline
// register enables/flushes and status out. master = pipeline side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  ex_mem_read;
    logic                  ex_wre;
    logic [REG_ADDR_W-1:0] ex_reg_dest;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  memwb_bubble;
    logic [1:0]            state_o;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_mem_read, ex_wre, ex_reg_dest, branch_taken,
        output mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en,
        input  ifid_flush, idex_flush, memwb_bubble,
        input  state_o, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_mem_read, ex_wre, ex_reg_dest, branch_taken,
        input  mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en,
        output ifid_flush, idex_flush, memwb_bubble,
        output state_o, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID source that matches a load's
// destination in EX. Ports: i_rs1/i_rs2/i_*_used, i_mem_read, i_wre, i_rd, o_lu.
module load_use_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic                  i_rs1_used,
    input  logic                  i_rs2_used,
    input  logic                  i_mem_read,
    input  logic                  i_wre,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  o_lu
);
    // Register 0 is an ordinary register in this ISA.
    assign o_lu = i_mem_read & i_wre &
                  ((i_rs1_used & (i_rs1 == i_rd)) |
                   (i_rs2_used & (i_rs2 == i_rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, taken branch, MEM wait FSM with
// watchdog and stall counter. Ports: clk, rst_n, hz (slave bundle).
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    logic           w_lu;
    logic           w_ms;
    hz_state_t      r_state;
    hz_state_t      w_state_nxt;
    logic [WCW-1:0] r_wait_cnt;
    logic [WCW-1:0] w_wait_nxt;
    logic           r_timeout;
    logic           w_timeout_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    hz_ctrl_t       w_ctrl;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
        .i_rs1      (hz.id_rs1),
        .i_rs2      (hz.id_rs2),
        .i_rs1_used (hz.id_rs1_used),
        .i_rs2_used (hz.id_rs2_used),
        .i_mem_read (hz.ex_mem_read),
        .i_wre      (hz.ex_wre),
        .i_rd       (hz.ex_reg_dest),
        .o_lu       (w_lu)
    );

    // A dropped mem_req counts as completion.
    assign w_ms = hz.mem_req & ~hz.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HZ_RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= w_timeout_nxt;
            if (!w_ctrl.pc_en && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_timeout;
        unique case (r_state)
            HZ_RUN: begin
                if (w_ms) begin
                    w_state_nxt = HZ_WAIT;
                    w_wait_nxt  = WCW'(1);
                end
            end
            HZ_WAIT: begin
                if (w_ms) begin
                    if (r_wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                        w_state_nxt   = HZ_ERROR;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end else begin
                    w_state_nxt = HZ_RUN;
                    w_wait_nxt  = '0;
                end
            end
            HZ_ERROR: ;
            default: w_state_nxt = HZ_RUN;
        endcase
    end

    // Controls are gated by rst_n directly so they drop without a clock.
    always_comb begin
        w_ctrl = '0;
        if (rst_n) begin
            unique case (r_state)
                HZ_RUN, HZ_WAIT:
                    w_ctrl = w_ms ? CTRL_MS
                                  : hz_decide(hz.branch_taken, w_lu);
                HZ_ERROR: w_ctrl = CTRL_MS;
                default:  w_ctrl = '0;
            endcase
        end
    end

    assign hz.pc_en        = w_ctrl.pc_en;
    assign hz.ifid_en      = w_ctrl.ifid_en;
    assign hz.idex_en      = w_ctrl.idex_en;
    assign hz.exmem_en     = w_ctrl.exmem_en;
    assign hz.ifid_flush   = w_ctrl.ifid_flush;
    assign hz.idex_flush   = w_ctrl.idex_flush;
    assign hz.memwb_bubble = w_ctrl.memwb_bubble;
    assign hz.state_o      = r_state;
    assign hz.mem_timeout  = r_timeout;
    assign hz.stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_err = 0;
    int   n_chk = 0;

    localparam logic [6:0] C_RUN = 7'b1111_000;
    localparam logic [6:0] C_BR  = 7'b1111_110;
    localparam logic [6:0] C_LU  = 7'b0011_010;
    localparam logic [6:0] C_MS  = 7'b0000_001;
    localparam logic [6:0] C_OFF = 7'b0000_000;

    typedef struct {
        string      nm;
        logic [6:0] ctl;
        logic [1:0] st;
        logic       tmo;
        logic [15:0] sc;
    } exp_t;
    exp_t q[$];

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) hz_if ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (4),
        .MEM_TIMEOUT(8),
        .CNT_W      (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input string f,
                       input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] a;
            e = q.pop_front();
            a = {hz_if.pc_en, hz_if.ifid_en, hz_if.idex_en, hz_if.exmem_en,
                 hz_if.ifid_flush, hz_if.idex_flush, hz_if.memwb_bubble};
            chk(e.nm, "ctl", {9'd0, a}, {9'd0, e.ctl});
            chk(e.nm, "state", {14'd0, hz_if.state_o}, {14'd0, e.st});
            chk(e.nm, "tmo", {15'd0, hz_if.mem_timeout}, {15'd0, e.tmo});
            chk(e.nm, "stall", hz_if.stall_cycles, e.sc);
        end
    end

    task automatic push(input string nm, input logic [6:0] ctl,
                        input logic [1:0] st, input logic tmo,
                        input int sc);
        exp_t e;
        e.nm  = nm;
        e.ctl = ctl;
        e.st  = st;
        e.tmo = tmo;
        e.sc  = 16'(sc);
        q.push_back(e);
    endtask

    task automatic idle();
        hz_if.id_rs1       = 4'd0;
        hz_if.id_rs2       = 4'd0;
        hz_if.id_rs1_used  = 1'b0;
        hz_if.id_rs2_used  = 1'b0;
        hz_if.ex_mem_read  = 1'b0;
        hz_if.ex_wre       = 1'b0;
        hz_if.ex_reg_dest  = 4'd0;
        hz_if.branch_taken = 1'b0;
        hz_if.mem_req      = 1'b0;
        hz_if.mem_ready    = 1'b0;
    endtask

    task automatic ld(input logic [3:0] rs1, input logic u1,
                      input logic [3:0] rs2, input logic u2,
                      input logic mr, input logic wre,
                      input logic [3:0] rd);
        hz_if.id_rs1      = rs1;
        hz_if.id_rs1_used = u1;
        hz_if.id_rs2      = rs2;
        hz_if.id_rs2_used = u2;
        hz_if.ex_mem_read = mr;
        hz_if.ex_wre      = wre;
        hz_if.ex_reg_dest = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic req, input logic rdy);
        hz_if.mem_req   = req;
        hz_if.mem_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        push("in_reset", C_OFF, 2'd0, 1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        step(); idle();
        push("run_idle", C_RUN, 2'd0, 1'b0, 0);

        step(); ld(4'd1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5);
        push("lu_rs2", C_LU, 2'd0, 1'b0, 0);
        step(); idle();
        push("lu_clear", C_RUN, 2'd0, 1'b0, 1);
        step(); ld(4'd5, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5);
        push("lu_unused", C_RUN, 2'd0, 1'b0, 1);
        step(); ld(4'd0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        push("lu_nowre", C_RUN, 2'd0, 1'b0, 1);
        step(); ld(4'd0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 4'd0);
        push("lu_r0", C_LU, 2'd0, 1'b0, 1);
        step(); hz_if.branch_taken = 1'b1;
        push("br_lu", C_BR, 2'd0, 1'b0, 2);
        step(); idle();
        push("after_br", C_RUN, 2'd0, 1'b0, 2);

        step(); mem(1'b1, 1'b0);
        push("ms_run", C_MS, 2'd0, 1'b0, 2);
        step();
        push("ms_w1", C_MS, 2'd1, 1'b0, 3);
        step();
        push("ms_w2", C_MS, 2'd1, 1'b0, 4);
        step(); mem(1'b1, 1'b1);
        push("ms_done", C_RUN, 2'd1, 1'b0, 5);
        step(); idle();
        push("ms_back", C_RUN, 2'd0, 1'b0, 5);

        step(); mem(1'b1, 1'b0);
        push("b2b_a", C_MS, 2'd0, 1'b0, 5);
        step(); mem(1'b1, 1'b1);
        ld(4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0);
        push("done_lu", C_LU, 2'd1, 1'b0, 6);
        step(); idle(); mem(1'b1, 1'b0);
        push("b2b_b", C_MS, 2'd0, 1'b0, 7);
        step(); mem(1'b0, 1'b0); hz_if.branch_taken = 1'b1;
        push("drop_br", C_BR, 2'd1, 1'b0, 8);
        step(); idle();
        push("drop_back", C_RUN, 2'd0, 1'b0, 8);

        step(); mem(1'b1, 1'b0);
        push("to_run", C_MS, 2'd0, 1'b0, 8);
        for (int i = 1; i <= 7; i++) begin
            step();
            push("to_wait", C_MS, 2'd1, 1'b0, 8 + i);
        end
        step();
        push("err_a", C_MS, 2'd2, 1'b1, 16);
        step(); mem(1'b1, 1'b1);
        push("err_rdy", C_MS, 2'd2, 1'b1, 17);
        step(); idle();
        push("err_idle", C_MS, 2'd2, 1'b1, 18);

        step(); rst_n = 1'b0;
        push("err_rst", C_OFF, 2'd0, 1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        push("err_exit", C_RUN, 2'd0, 1'b0, 0);

        step(); mem(1'b1, 1'b0);
        push("mw_a", C_MS, 2'd0, 1'b0, 0);
        step();
        push("mw_b", C_MS, 2'd1, 1'b0, 1);
        step(); rst_n = 1'b0;
        push("mw_rst", C_OFF, 2'd0, 1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle();
        step();
        push("mw_exit", C_RUN, 2'd0, 1'b0, 0);

        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
